counting_gen: RTL and testbench
===============================

# counting_gen

Symbol-sequence generator for the 2-bit `num` pattern stream consumed by the counting detector. It is the transmit side of the same interface. On a start request it drives one or more frames of the form `1`, then a run of `2`s, then a run of `3`s, with a `0` separator between frames. It returns to idle with a one-cycle `done` pulse. It sits in front of the detector in self-checking benches and in any datapath that must provoke the detector's `ans` condition deterministically.

## Interface
- `CNT_W`, default 4: width of the run-length and frame-count inputs.
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `start`  input  1  request a transfer; sampled only in IDLE.
- `abort`  input  1  terminate the transfer; sampled in any non-IDLE state.
- `n_two`  input  CNT_W  number of `2` symbols per frame; 0 is treated as 1.
- `n_three`  input  CNT_W  number of `3` symbols per frame; 0 is treated as 1.
- `n_frame`  input  CNT_W  number of frames; 0 is treated as 1.
- `num`  output  2  symbol stream; registered.
- `busy`  output  1  high from the cycle after an accepted start through the last symbol of the last frame.
- `frame_done`  output  1  one-cycle pulse, high during the last `3` of each frame.
- `done`  output  1  one-cycle pulse after normal completion.

## Operation
- **Reset.** While `rst_n`=0 at a rising edge, the block enters IDLE on the next cycle with `num`=0, `busy`=0, `frame_done`=0 and `done`=0. All counters clear. Reset overrides `start` and `abort` and applies mid-transfer with no `done`.
- **States.** IDLE, ONE, TWO, THREE and SEP.
- **IDLE.**
  - Drives `num`=0.
  - If `start`=1, the block latches `n_two`, `n_three` and `n_frame` (zero promoted to 1) into internal registers and goes to ONE.
  - Input changes after acceptance have no effect on the running transfer.
- **ONE.** Drives `num`=1 for exactly one cycle, then goes to TWO.
- **TWO.** Drives `num`=2 for exactly the latched `n_two` cycles, then goes to THREE.
- **THREE.**
  - Drives `num`=3 for exactly the latched `n_three` cycles.
  - `frame_done`=1 on the last of these cycles.
  - Then goes to SEP if frames remain, else to IDLE.
- **SEP.** Drives `num`=0 for exactly one cycle, then goes to ONE.
- **Run counters.**
  - Each run counter is CNT_W bits, loads with the run length and decrements to 1. There is no wrap.
  - The maximum run is 2^CNT_W−1.
  - The frame counter decrements at each `frame_done`.
- **`done`.** Asserted for one cycle, the cycle in which the block is back in IDLE with `num`=0, following the last `3` of the last frame after normal completion.
- **`start` handling.**
  - `start` while not in IDLE is ignored and never queued.
  - `start` in the same cycle that `done` is high is accepted, because the state is IDLE. The next `num`=1 follows immediately, giving a single `0` gap.
- **`abort`.**
  - `abort`=1 in any non-IDLE state forces IDLE on the next edge: `num`=0, `busy`=0, no `done`, no `frame_done` in that cycle.
  - `abort` has priority over a `frame_done` that would otherwise occur in that cycle.
  - `abort` in IDLE is ignored.
  - `abort` and `start` together in IDLE: `start` wins.
- **Per-frame length.** Symbols per frame = 1 + n_two + n_three, with a separator between frames but not after the last.
- **Total transfer length.** busy cycles = n_frame·(1+n_two+n_three) + (n_frame−1).

## Timing
- **Start latency.** `start` is sampled at edge E. `num`=1 and `busy`=1 hold from E until E+1.
- **Register outputs.** `num`, `busy`, `frame_done` and `done` are all registered, with no combinational path from any input.
- **Handshake.** `start` needs only a one-cycle pulse; holding it high restarts back-to-back transfers with one `0` cycle between them.
- **Detector alignment.** A detector sampling `num` on the following edge sees 1→2…→3 and raises `ans` one cycle after the first `3`.
- **Abort latency.** One edge.

## Test plan
- **Single frame.** Reset, then `start` with n_two=1, n_three=1, n_frame=1.
  - `num` = 0,1,2,3,0.
  - `busy` is high 3 cycles.
  - `frame_done` is high on the `3`.
  - `done` is high on the following `0`.
  - The chained detector gives `ans`=1.
- **Multi-frame.** n_two=2, n_three=3, n_frame=2.
  - `num` = 1,2,2,3,3,3,0,1,2,2,3,3,3 then 0.
  - `busy` is high 13 cycles.
  - Two `frame_done` pulses, one `done`.
- **Zero promotion.** n_two=0, n_three=0, n_frame=0 behaves identically to all-ones: `num` = 1,2,3, then `done`.
- **Ignore while busy.**
  - Pulse `start` during TWO with different counts: no effect on the sequence.
  - Hold `start` high through `done`: a second transfer begins with exactly one `0` cycle between them.
- **Abort.**
  - Assert `abort` during the second `3` of n_three=3: `num`=0 on the next cycle, `busy`=0, no `frame_done`, no `done`.
  - A subsequent `start` works normally.
- **Reset mid-transfer.**
  - Drive `rst_n`=0 for one edge during TWO of a run with n_two=15 (CNT_W=4): all outputs are 0 next cycle and no `done`.
  - A max-length run of 15 `2`s then completes correctly after restart.

Source files
------------

// File: rtl/counting_gen_if.sv
// Request/stream bundle between a counting_gen and whoever commands it.
// The commander drives the request side; the generator drives the symbol stream and status.
interface counting_gen_if #(
  parameter int CNT_W = 4
) ();
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_two;
  logic [CNT_W-1:0] n_three;
  logic [CNT_W-1:0] n_frame;
  logic [1:0]       num;
  logic             busy;
  logic             frame_done;
  logic             done;

  modport master (
    output start, abort, n_two, n_three, n_frame,
    input  num, busy, frame_done, done
  );

  modport slave (
    input  start, abort, n_two, n_three, n_frame,
    output num, busy, frame_done, done
  );
endinterface

// File: rtl/counting_gen.sv
// Emits frames of 1, a run of 2s and a run of 3s, with a 0 between frames.
// All outputs are registered and are computed from the state being entered.
module counting_gen #(
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  counting_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ONE   = 3'd1,
    TWO   = 3'd2,
    THREE = 3'd3,
    SEP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] frm_r, frm_s;
  logic [CNT_W-1:0] n2_r, n2_s;
  logic [CNT_W-1:0] n3_r, n3_s;
  logic [1:0]       num_r, num_s;
  logic             busy_r, busy_s;
  logic             fd_r, fd_s;
  logic             done_r, done_s;

  function automatic logic [CNT_W-1:0] promote(input logic [CNT_W-1:0] v);
    promote = (v == {CNT_W{1'b0}}) ? CNT_ONE : v;
  endfunction

  // Next state, counters and the output values for the cycle being entered
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    frm_s   = frm_r;
    n2_s    = n2_r;
    n3_s    = n3_r;
    num_s   = 2'd0;
    busy_s  = 1'b0;
    fd_s    = 1'b0;
    done_s  = 1'b0;
    if ((state_r != IDLE) && bus.abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            n2_s    = promote(bus.n_two);
            n3_s    = promote(bus.n_three);
            frm_s   = promote(bus.n_frame);
            state_s = ONE;
            num_s   = 2'd1;
            busy_s  = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        ONE: begin
          state_s = TWO;
          cnt_s   = n2_r;
          num_s   = 2'd2;
          busy_s  = 1'b1;
        end
        TWO: begin
          busy_s = 1'b1;
          if (cnt_r == CNT_ONE) begin
            state_s = THREE;
            cnt_s   = n3_r;
            num_s   = 2'd3;
            fd_s    = (n3_r == CNT_ONE);
          end else begin
            cnt_s = cnt_r - CNT_ONE;
            num_s = 2'd2;
          end
        end
        THREE: begin
          if (cnt_r != CNT_ONE) begin
            cnt_s  = cnt_r - CNT_ONE;
            num_s  = 2'd3;
            busy_s = 1'b1;
            fd_s   = (cnt_r == (CNT_ONE + CNT_ONE));
          end else if (frm_r > CNT_ONE) begin
            // the frame that just ended is retired here; the separator keeps busy high
            frm_s   = frm_r - CNT_ONE;
            state_s = SEP;
            busy_s  = 1'b1;
          end else begin
            frm_s   = {CNT_W{1'b0}};
            state_s = IDLE;
            done_s  = 1'b1;
          end
        end
        SEP: begin
          state_s = ONE;
          num_s   = 2'd1;
          busy_s  = 1'b1;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      frm_r   <= {CNT_W{1'b0}};
      n2_r    <= {CNT_W{1'b0}};
      n3_r    <= {CNT_W{1'b0}};
      num_r   <= 2'd0;
      busy_r  <= 1'b0;
      fd_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      frm_r   <= frm_s;
      n2_r    <= n2_s;
      n3_r    <= n3_s;
      num_r   <= num_s;
      busy_r  <= busy_s;
      fd_r    <= fd_s;
      done_r  <= done_s;
    end
  end

  assign bus.num        = num_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = fd_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_counting_gen.sv
// Scoreboard bench for counting_gen: each scenario queues the expected per-cycle
// {num,busy,frame_done,done} tuples and then drains them against the DUT.
module tb_counting_gen;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic [4:0] exp_q[$];

  counting_gen_if #(.CNT_W(CNT_W)) bus ();

  counting_gen #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void push(input logic [1:0] n, input logic b, input logic f, input logic d);
    exp_q.push_back({n, b, f, d});
  endfunction

  // Reference sequence of a complete transfer, ending with its done cycle
  function automatic void push_transfer(input int n2, input int n3, input int nf);
    int a = (n2 == 0) ? 1 : n2;
    int b = (n3 == 0) ? 1 : n3;
    int c = (nf == 0) ? 1 : nf;
    for (int f = 0; f < c; f++) begin
      push(2'd1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < a; i++) push(2'd2, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < b; i++) push(2'd3, 1'b1, (i == b - 1), 1'b0);
      if (f < c - 1) push(2'd0, 1'b1, 1'b0, 1'b0);
    end
    push(2'd0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic set_counts(input int n2, input int n3, input int nf);
    bus.n_two   = 4'(n2);
    bus.n_three = 4'(n3);
    bus.n_frame = 4'(nf);
  endtask

  task automatic test_reset();
    int idx = 0;
    logic [4:0] e, obs;
    rst_n = 1'b0; bus.start = 1'b1; bus.abort = 1'b1;
    set_counts(5, 5, 5);
    repeat (4) push(2'd0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {bus.num, bus.busy, bus.frame_done, bus.done};
      n_cmp++;
      if (obs !== e) begin
        n_mis++;
        $display("FAIL reset[%0d] got %b expected %b", idx, obs, e);
      end
      if (idx == 0) begin bus.start = 1'b0; bus.abort = 1'b0; end
      if (idx == 1) rst_n = 1'b1;
      idx++;
    end
  endtask

  task automatic test_transfer(input string name, input int n2, input int n3, input int nf);
    int idx = 0;
    logic [4:0] e, obs;
    @(negedge clk);
    set_counts(n2, n3, nf);
    bus.start = 1'b1;
    push_transfer(n2, n3, nf);
    push(2'd0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {bus.num, bus.busy, bus.frame_done, bus.done};
      n_cmp++;
      if (obs !== e) begin
        n_mis++;
        $display("FAIL %s[%0d] got %b expected %b", name, idx, obs, e);
      end
      if (idx == 0) bus.start = 1'b0;
      idx++;
    end
  endtask

  task automatic test_ignore_busy();
    int idx = 0;
    logic [4:0] e, obs;
    @(negedge clk);
    set_counts(3, 2, 1);
    bus.start = 1'b1;
    push_transfer(3, 2, 1);
    push(2'd0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {bus.num, bus.busy, bus.frame_done, bus.done};
      n_cmp++;
      if (obs !== e) begin
        n_mis++;
        $display("FAIL ignore_busy[%0d] got %b expected %b", idx, obs, e);
      end
      if (idx == 0) bus.start = 1'b0;
      if (idx == 1) begin bus.start = 1'b1; set_counts(7, 9, 3); end
      if (idx == 2) bus.start = 1'b0;
      idx++;
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    logic [4:0] e, obs;
    @(negedge clk);
    set_counts(2, 1, 1);
    bus.start = 1'b1;
    push_transfer(2, 1, 1);
    push_transfer(2, 1, 1);
    push(2'd0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {bus.num, bus.busy, bus.frame_done, bus.done};
      n_cmp++;
      if (obs !== e) begin
        n_mis++;
        $display("FAIL back_to_back[%0d] got %b expected %b", idx, obs, e);
      end
      if (idx == 5) bus.start = 1'b0;
      idx++;
    end
  endtask

  task automatic test_abort();
    int idx = 0;
    logic [4:0] e, obs;
    @(negedge clk);
    set_counts(1, 3, 1);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    push(2'd1, 1'b1, 1'b0, 1'b0);
    push(2'd2, 1'b1, 1'b0, 1'b0);
    push(2'd3, 1'b1, 1'b0, 1'b0);
    push(2'd3, 1'b1, 1'b0, 1'b0);
    push(2'd0, 1'b0, 1'b0, 1'b0);
    push(2'd0, 1'b0, 1'b0, 1'b0);
    push(2'd0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {bus.num, bus.busy, bus.frame_done, bus.done};
      n_cmp++;
      if (obs !== e) begin
        n_mis++;
        $display("FAIL abort[%0d] got %b expected %b", idx, obs, e);
      end
      if (idx == 0) begin bus.start = 1'b0; bus.abort = 1'b0; end
      if (idx == 3) bus.abort = 1'b1;
      if (idx == 4) bus.abort = 1'b1;
      if (idx == 5) bus.abort = 1'b0;
      idx++;
    end
    test_transfer("after_abort", 2, 1, 1);
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    logic [4:0] e, obs;
    @(negedge clk);
    set_counts(15, 1, 1);
    bus.start = 1'b1;
    push(2'd1, 1'b1, 1'b0, 1'b0);
    push(2'd2, 1'b1, 1'b0, 1'b0);
    push(2'd2, 1'b1, 1'b0, 1'b0);
    push(2'd0, 1'b0, 1'b0, 1'b0);
    push(2'd0, 1'b0, 1'b0, 1'b0);
    push(2'd0, 1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {bus.num, bus.busy, bus.frame_done, bus.done};
      n_cmp++;
      if (obs !== e) begin
        n_mis++;
        $display("FAIL reset_mid[%0d] got %b expected %b", idx, obs, e);
      end
      if (idx == 0) bus.start = 1'b0;
      if (idx == 2) rst_n = 1'b0;
      if (idx == 3) rst_n = 1'b1;
      idx++;
    end
    test_transfer("max_run", 15, 2, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_counts(0, 0, 0);
    test_reset();
    test_transfer("single", 1, 1, 1);
    test_transfer("multi", 2, 3, 2);
    test_transfer("zero_promo", 0, 0, 0);
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
